alu_operand_stage: RTL

//  Registered ALU operand stage with forwarding; sits between decode/regfile read and the ALU.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_fwd_mux.sv | 25 ++
 rtl/alu_operand_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand stage: operand source selects and
// the skid-buffer occupancy states.
package alu_pkg;

  localparam logic ASRC_RS1 = 1'b0;
  localparam logic ASRC_PC  = 1'b1;

  localparam logic [1:0] BSRC_RS2   = 2'b00;
  localparam logic [1:0] BSRC_SHAMT = 2'b01;
  localparam logic [1:0] BSRC_INC   = 2'b10;
  localparam logic [1:0] BSRC_ZERO  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Shift-amount field width for a given datapath width (5 for 32, 6 for 64).
  function automatic int shamt_width(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Priority bypass for one source operand: the youngest matching valid
// forwarding source wins, and x0 always reads the regfile value.
module alu_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]              rs_addr,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic [XLEN-1:0]         rs_data
);

  // Walk from oldest to youngest so the lowest matching index is the last write.
  always_comb begin
    rs_data = rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_addr[5*i +: 5] == rs_addr) && (rs_addr != 5'd0)) begin
        rs_data = fwd_data[XLEN*i +: XLEN];
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: forwards rs1/rs2, selects A/B and hands them
// to the ALU through a two-entry valid/ready skid buffer.
//
//  state    | meaning
//  ---------+------------------------------------------------
//  ST_EMPTY | nothing buffered, out_valid low
//  ST_ONE   | output registers hold a bundle
//  ST_FULL  | output registers and skid register both hold a bundle
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int PC_INC  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_rs1_data,
  input  logic [XLEN-1:0]         in_rs2_data,
  input  logic [4:0]              in_rs1_addr,
  input  logic [4:0]              in_rs2_addr,
  input  logic [XLEN-1:0]         in_imm,
  input  logic                    in_asrc,
  input  logic [1:0]              in_bsrc,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_a,
  output logic [XLEN-1:0]         out_b
);

  localparam int SHAMT_W = shamt_width(XLEN);
  localparam logic [XLEN-1:0] SHAMT_MASK = XLEN'((64'd1 << SHAMT_W) - 64'd1);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } opnd_t;

  state_t          state;
  state_t          state_nxt;
  opnd_t           out_q;
  opnd_t           skid_q;
  opnd_t           sel;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            accept;
  logic            deliver;

  alu_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs_addr   (in_rs1_addr),
    .rf_data   (in_rs1_data),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .rs_data   (rs1_fwd)
  );

  alu_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs_addr   (in_rs2_addr),
    .rf_data   (in_rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .rs_data   (rs2_fwd)
  );

  // Masking the full immediate is the same as zero-extending its low SHAMT_W bits.
  always_comb begin
    sel   = '0;
    sel.a = (in_asrc == ASRC_PC) ? in_pc : rs1_fwd;
    case (in_bsrc)
      BSRC_RS2:   sel.b = rs2_fwd;
      BSRC_SHAMT: sel.b = in_imm & SHAMT_MASK;
      BSRC_INC:   sel.b = XLEN'(PC_INC);
      BSRC_ZERO:  sel.b = '0;
      default:    sel.b = '0;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !deliver) state_nxt = ST_FULL;
        else if (!accept && deliver) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (deliver) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // in_ready depends only on the state register (and reset), never on out_ready.
  always_comb begin
    in_ready  = rst_n && (state != ST_FULL);
    out_valid = (state != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state)
        ST_EMPTY: if (accept) out_q <= sel;
        ST_ONE: begin
          if (accept && deliver) out_q <= sel;
          else if (accept) skid_q <= sel;
        end
        ST_FULL:  if (deliver) out_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_a = out_q.a;
  assign out_b = out_q.b;

endmodule
